// File: rtl/dst_reg_pipe_e_if.sv
// E-stage destination-select bus for dst_reg_pipe_e: E-stage instruction fields in, E/M register contents out.
// The master drives the E-stage fields; the slave is the pipeline register.
interface dst_reg_pipe_e_if #(
    parameter int AW = 5,
    parameter int DW = 32,
    parameter int TW = 2,
    parameter int CW = 16
);
    logic          valid_E;
    logic [AW-1:0] rt_E;
    logic [AW-1:0] rd_E;
    logic [1:0]    dst_sel_E;
    logic          cmov_E;
    logic          cmov_neg_E;
    logic [DW-1:0] rt_val_E;
    logic [TW-1:0] tnew_E;

    logic          valid_M;
    logic [AW-1:0] dst_M;
    logic          wr_en_M;
    logic [TW-1:0] tnew_M;
    logic [CW-1:0] cmov_kill_cnt;

    modport master (
        output valid_E, rt_E, rd_E, dst_sel_E, cmov_E, cmov_neg_E, rt_val_E, tnew_E,
        input  valid_M, dst_M, wr_en_M, tnew_M, cmov_kill_cnt
    );

    modport slave (
        input  valid_E, rt_E, rd_E, dst_sel_E, cmov_E, cmov_neg_E, rt_val_E, tnew_E,
        output valid_M, dst_M, wr_en_M, tnew_M, cmov_kill_cnt
    );
endinterface

// File: rtl/dst_reg_pipe_e.sv
// E-stage destination mux with conditional-move kill, registered into the E/M boundary.
// Optional macro DST_PIPE_MOVN_EN: cmov_neg_E selects movn (write when rt != 0) instead of movz.
module dst_reg_pipe_e #(
    parameter int AW = 5,
    parameter int DW = 32,
    parameter int TW = 2,
    parameter int CW = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    dst_reg_pipe_e_if.slave   bus
);

    localparam logic [1:0] SEL_RT   = 2'b00;
    localparam logic [1:0] SEL_RD   = 2'b01;
    localparam logic [1:0] SEL_RA   = 2'b10;
    localparam logic [1:0] SEL_NONE = 2'b11;

    // Tnew counts down one per cycle and never goes below zero.
    function automatic logic [TW-1:0] tnew_dec(input logic [TW-1:0] t);
        logic [TW-1:0] r;
        if (t == {TW{1'b0}}) begin
            r = {TW{1'b0}};
        end else begin
            r = t - {{(TW-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

    logic [AW-1:0] sel_dst_s;
    logic          cond_s;
    logic          kill_s;
    logic [AW-1:0] next_dst_s;

    logic          valid_d, valid_q;
    logic [AW-1:0] dst_d,   dst_q;
    logic          wr_en_d, wr_en_q;
    logic [TW-1:0] tnew_d,  tnew_q;
    logic [CW-1:0] cnt_d,   cnt_q;

    // Raw destination according to the selector.
    always_comb begin
        sel_dst_s = {AW{1'b0}};
        case (bus.dst_sel_E)
            SEL_RT:   sel_dst_s = bus.rt_E;
            SEL_RD:   sel_dst_s = bus.rd_E;
            SEL_RA:   sel_dst_s = {AW{1'b1}};
            SEL_NONE: sel_dst_s = {AW{1'b0}};
            default:  sel_dst_s = {AW{1'b0}};
        endcase
    end

`ifdef DST_PIPE_MOVN_EN
    // movn inverts the zero test; movz is the plain test.
    always_comb begin
        cond_s = 1'b0;
        if (bus.cmov_neg_E) begin
            cond_s = (bus.rt_val_E != {DW{1'b0}});
        end else begin
            cond_s = (bus.rt_val_E == {DW{1'b0}});
        end
    end
`else
    logic unused_cmov_neg_s;
    assign unused_cmov_neg_s = bus.cmov_neg_E;

    // Every conditional move is movz in this build.
    always_comb begin
        cond_s = (bus.rt_val_E == {DW{1'b0}});
    end
`endif

    // A kill needs a real destination to suppress; "none" is never counted.
    always_comb begin
        kill_s     = 1'b0;
        next_dst_s = {AW{1'b0}};
        if (!bus.valid_E) begin
            kill_s     = 1'b0;
            next_dst_s = {AW{1'b0}};
        end else if (bus.cmov_E && !cond_s) begin
            kill_s     = (bus.dst_sel_E != SEL_NONE);
            next_dst_s = {AW{1'b0}};
        end else begin
            kill_s     = 1'b0;
            next_dst_s = sel_dst_s;
        end
    end

    // Next E/M state: flush beats stall beats load.
    always_comb begin
        valid_d = valid_q;
        dst_d   = dst_q;
        wr_en_d = wr_en_q;
        tnew_d  = tnew_q;
        cnt_d   = cnt_q;
        if (flush) begin
            valid_d = 1'b0;
            dst_d   = {AW{1'b0}};
            wr_en_d = 1'b0;
            tnew_d  = {TW{1'b0}};
        end else if (stall) begin
            tnew_d  = tnew_dec(tnew_q);
        end else begin
            valid_d = bus.valid_E;
            dst_d   = next_dst_s;
            wr_en_d = bus.valid_E && (next_dst_s != {AW{1'b0}});
            tnew_d  = tnew_dec(bus.tnew_E);
            if (kill_s) begin
                cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
            end else begin
                cnt_d = cnt_q;
            end
        end
    end

    // E/M register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            dst_q   <= {AW{1'b0}};
            wr_en_q <= 1'b0;
            tnew_q  <= {TW{1'b0}};
            cnt_q   <= {CW{1'b0}};
        end else begin
            valid_q <= valid_d;
            dst_q   <= dst_d;
            wr_en_q <= wr_en_d;
            tnew_q  <= tnew_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.valid_M       = valid_q;
    assign bus.dst_M         = dst_q;
    assign bus.wr_en_M       = wr_en_q;
    assign bus.tnew_M        = tnew_q;
    assign bus.cmov_kill_cnt = cnt_q;

endmodule

// File: doc/dst_reg_pipe_e.md
Name: dst_reg_pipe_E

Overview:
- Parametrised successor to the E-stage conditional-move destination mux.
- Selects the destination register for the instruction in E: rt, rd, $ra, or none.
- For movz, forces the destination to $0 when the move condition fails. With the optional feature, movn is handled the same way.
- Registers the result into the E/M boundary, together with a Tnew countdown for the hazard unit and a counter of suppressed conditional writes.

Parameters:
- AW, 5, register-address width; $ra = all ones (31 at AW=5).
- DW, 32, width of the compared register value.
- TW, 2, width of the Tnew field.
- CW, 16, width of the suppressed-write counter.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hold the E/M register contents.
- flush  in  1  load a bubble.
- valid_E  in  1  E-stage instruction is real.
- rt_E  in  AW  rt field.
- rd_E  in  AW  rd field.
- dst_sel_E  in  2  destination source: 00 rt, 01 rd, 10 $ra, 11 none.
- cmov_E  in  1  instruction is a conditional move.
- cmov_neg_E  in  1  1 = movn; ignored unless the optional macro is defined.
- rt_val_E  in  DW  forwarded GPR[rt] value.
- tnew_E  in  TW  Tnew of the instruction while in E.
- valid_M  out  1  registered valid.
- dst_M  out  AW  registered destination; 0 means no write.
- wr_en_M  out  1  valid_M && dst_M != 0.
- tnew_M  out  TW  Tnew as seen from M.
- cmov_kill_cnt  out  CW  count of suppressed conditional writes.

Behaviour:
- Combinational pre-select:
  - sel_dst = rt_E, rd_E, {AW{1'b1}} or 0, according to dst_sel_E.
  - cond = (rt_val_E == 0); with the macro defined and cmov_neg_E=1, cond = (rt_val_E != 0).
  - If cmov_E && !cond, next_dst = 0 (kill). Otherwise next_dst = sel_dst.
  - If valid_E=0, next_dst = 0.
- Sequential update at each posedge clk, in priority order: reset > flush > stall > load.
  - reset: valid_M=0, dst_M=0, tnew_M=0, cmov_kill_cnt=0. All outputs are 0 after reset; wr_en_M=0.
  - flush: valid_M=0, dst_M=0, tnew_M=0. cmov_kill_cnt holds; a flushed instruction is never counted.
  - stall:
    - valid_M and dst_M hold.
    - tnew_M decrements by 1, saturating at 0, because time still elapses for the held result.
    - No count.
  - load:
    - valid_M = valid_E.
    - dst_M = next_dst.
    - tnew_M = (tnew_E == 0) ? 0 : tnew_E - 1.
- Kill counter:
  - Increments by 1 only on a load cycle with valid_E && cmov_E && !cond.
  - Wraps modulo 2^CW.
- Simultaneous events: flush with stall behaves as flush. Reset overrides all.
- Latency: 1 cycle from E inputs to M outputs; no combinational path from inputs to outputs.
- Non-cmov instructions (cmov_E=0) ignore rt_val_E entirely.
- dst_sel_E=11 gives dst_M=0 and does not count as a kill.

Optional Feature:
- Macro: DST_PIPE_MOVN_EN.
- Defined: cmov_neg_E selects the inverted condition (movn semantics); kills are counted the same way.
- Undefined:
  - cmov_neg_E is ignored; every cmov is movz.
  - The port still exists so that instantiations are unchanged.

Test Plan:
1. Reset released, no valid input -> valid_M=0, dst_M=0, tnew_M=0, cmov_kill_cnt=0, wr_en_M=0.
2. valid_E=1, dst_sel_E=01, rd_E=8, cmov_E=1, rt_val_E=0, tnew_E=1 -> next cycle dst_M=8, wr_en_M=1, tnew_M=0, cnt=0. Same inputs with rt_val_E=5 -> dst_M=0, wr_en_M=0, cnt=1.
3. dst_sel_E=10, tnew_E=2, then stall for 3 cycles -> dst_M=31 throughout, tnew_M sequence 1,0,0.
4. stall=1 and flush=1 in the same cycle while holding dst_M=8 -> dst_M=0, valid_M=0, cnt unchanged.
5. Macro defined, cmov_neg_E=1, rd_E=9, rt_val_E=0 -> dst_M=0, cnt+1. Same with rt_val_E=7 -> dst_M=9. Macro undefined, rt_val_E=0 -> dst_M=9.
6. CW=2, four kills -> cnt sequence 1,2,3,0. Reset asserted mid-stream -> all outputs 0 on the next edge.
